// File: rtl/clk_duty_monitor.sv
// Measures high/low/period of an asynchronous mon_clk in core clk cycles; results publish 1 clk after the synchronized rise
// is detected (SYNC_STAGES+1 edges after the transition). No backpressure: meas_valid is a fire-and-forget pulse.
module clk_duty_monitor #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mon_clk,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] low_cnt,
    output logic [CNT_W:0]   period_cnt,
    output logic             meas_valid,
    output logic             stuck,
    output logic             stuck_level
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ALIGN   = 2'd1,
        MEAS_HI = 2'd2,
        MEAS_LO = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    // Counters stop one short of all-ones: the step that would reach it is the timeout.
    localparam logic [CNT_W-1:0] CNT_LIM = {{(CNT_W-1){1'b1}}, 1'b0};

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync_lvl;
    logic                   prev_lvl;
    logic                   rise;
    logic                   fall;

    state_t           state;
    logic [CNT_W-1:0] hi_ctr;
    logic [CNT_W-1:0] lo_ctr;
    logic [CNT_W-1:0] tmo_ctr;
    logic [CNT_W-1:0] hi_lat;
    logic             tmo_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff  <= '0;
            prev_lvl <= 1'b0;
        end else begin
            sync_ff  <= {sync_ff[SYNC_STAGES-2:0], mon_clk};
            prev_lvl <= sync_ff[SYNC_STAGES-1];
        end
    end

    assign sync_lvl = sync_ff[SYNC_STAGES-1];
    assign rise     = sync_lvl & ~prev_lvl;
    assign fall     = ~sync_lvl & prev_lvl;

    // An edge in the timeout cycle always takes priority, so the edge terms gate each hit.
    always_comb begin
        tmo_hit = 1'b0;
        case (state)
            ALIGN:   tmo_hit = !rise && (tmo_ctr == CNT_LIM);
            MEAS_HI: tmo_hit = !fall && (hi_ctr == CNT_LIM);
            MEAS_LO: tmo_hit = !rise && (lo_ctr == CNT_LIM);
            default: tmo_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            hi_ctr      <= '0;
            lo_ctr      <= '0;
            tmo_ctr     <= '0;
            hi_lat      <= '0;
            high_cnt    <= '0;
            low_cnt     <= '0;
            period_cnt  <= '0;
            meas_valid  <= 1'b0;
            stuck       <= 1'b0;
            stuck_level <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (!en) begin
                state   <= IDLE;
                hi_ctr  <= '0;
                lo_ctr  <= '0;
                tmo_ctr <= '0;
                hi_lat  <= '0;
            end else if (tmo_hit) begin
                state       <= ALIGN;
                hi_ctr      <= '0;
                lo_ctr      <= '0;
                tmo_ctr     <= '0;
                hi_lat      <= '0;
                stuck       <= 1'b1;
                stuck_level <= sync_lvl;
            end else begin
                case (state)
                    IDLE: begin
                        hi_ctr  <= '0;
                        lo_ctr  <= '0;
                        tmo_ctr <= '0;
                        hi_lat  <= '0;
                        state   <= ALIGN;
                    end
                    ALIGN: begin
                        if (rise) begin
                            hi_ctr  <= CNT_ONE;
                            tmo_ctr <= '0;
                            state   <= MEAS_HI;
                        end else begin
                            tmo_ctr <= tmo_ctr + CNT_ONE;
                        end
                    end
                    MEAS_HI: begin
                        if (fall) begin
                            hi_lat <= hi_ctr;
                            lo_ctr <= CNT_ONE;
                            state  <= MEAS_LO;
                        end else begin
                            hi_ctr <= hi_ctr + CNT_ONE;
                        end
                    end
                    MEAS_LO: begin
                        if (rise) begin
                            high_cnt   <= hi_lat;
                            low_cnt    <= lo_ctr;
                            period_cnt <= {1'b0, hi_lat} + {1'b0, lo_ctr};
                            meas_valid <= 1'b1;
                            stuck      <= 1'b0;
                            hi_ctr     <= CNT_ONE;
                            lo_ctr     <= '0;
                            state      <= MEAS_HI;
                        end else begin
                            lo_ctr <= lo_ctr + CNT_ONE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clk_duty_monitor.sv
// Directed + randomized bench for clk_duty_monitor: mon_clk is driven in whole clk-cycle phases and checked against a phase-list model.
module tb_clk_duty_monitor;

    localparam int W   = 8;
    localparam int LIM = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         mon_clk = 1'b0;
    logic [W-1:0] high_cnt;
    logic [W-1:0] low_cnt;
    logic [W:0]   period_cnt;
    logic         meas_valid;
    logic         stuck;
    logic         stuck_level;

    clk_duty_monitor #(.CNT_W(W), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .mon_clk     (mon_clk),
        .high_cnt    (high_cnt),
        .low_cnt     (low_cnt),
        .period_cnt  (period_cnt),
        .meas_valid  (meas_valid),
        .stuck       (stuck),
        .stuck_level (stuck_level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int q_h[$];
    int q_l[$];
    int cyc = 0;
    int pulse_cyc = -1;
    int prev_pulse_cyc = -1;

    // Reference model: a period is reported when a rise follows a complete high+low pair seen since the last restart.
    bit aligned = 1'b0;
    bit have_lo = 1'b0;
    int m_hi = 0;
    int m_lo = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_phase(input bit lvl, input int n);
        if (lvl) begin
            if (aligned && have_lo) begin
                q_h.push_back(m_hi);
                q_l.push_back(m_lo);
            end
            aligned = 1'b1;
            have_lo = 1'b0;
            m_hi    = n;
            if (n >= LIM) aligned = 1'b0;
        end else if (aligned) begin
            m_lo    = n;
            have_lo = 1'b1;
            if (n >= LIM) aligned = 1'b0;
        end
    endtask

    task automatic restart_model();
        aligned = 1'b0;
        have_lo = 1'b0;
    endtask

    task automatic drive(input bit lvl, input int n);
        mon_clk = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ph(input bit lvl, input int n);
        model_phase(lvl, n);
        drive(lvl, n);
    endtask

    always @(negedge clk) begin
        int eh;
        int el;
        cyc++;
        if (rst_n && meas_valid === 1'b1) begin
            prev_pulse_cyc = pulse_cyc;
            pulse_cyc      = cyc;
            checks++;
            assert (q_h.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_pulse observed=%0d/%0d expected=no pulse", high_cnt, low_cnt);
            end
            if (q_h.size() > 0) begin
                eh = q_h.pop_front();
                el = q_l.pop_front();
                chk("pub_high", 32'(high_cnt), eh);
                chk("pub_low", 32'(low_cnt), el);
                chk("pub_period", 32'(period_cnt), eh + el);
                chk("pub_stuck_clr", 32'(stuck), 0);
            end
        end
    end

    initial begin
        int h;
        int l;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_high", 32'(high_cnt), 0);
        chk("rst_low", 32'(low_cnt), 0);
        chk("rst_period", 32'(period_cnt), 0);
        chk("rst_valid", 32'(meas_valid), 0);
        chk("rst_stuck", 32'(stuck), 0);
        chk("rst_stuck_lvl", 32'(stuck_level), 0);

        // Held-low input: ALIGN times out exactly LIM cycles after it is entered.
        rst_n = 1'b1;
        drive(1'b0, 2);
        en = 1'b1;
        @(posedge clk);
        #1;
        repeat (LIM - 1) @(posedge clk);
        #1;
        chk("align_stuck_early", 32'(stuck), 0);
        @(posedge clk);
        #1;
        chk("align_stuck_set", 32'(stuck), 1);
        chk("align_stuck_lvl", 32'(stuck_level), 0);

        for (int i = 0; i < 7; i++) begin
            ph(1'b1, 5);
            ph(1'b0, 5);
        end
        chk("stuck_cleared", 32'(stuck), 0);
        chk("pulse_interval", 32'(pulse_cyc - prev_pulse_cyc), 10);

        for (int i = 0; i < 5; i++) begin
            ph(1'b1, 3);
            ph(1'b0, 7);
        end
        for (int i = 0; i < 5; i++) begin
            ph(1'b1, 7);
            ph(1'b0, 3);
        end

        // Longest measurable phases, period past CNT_W bits.
        ph(1'b1, LIM - 1);
        ph(1'b0, 5);
        ph(1'b1, 5);
        ph(1'b0, LIM - 1);
        ph(1'b1, 5);
        ph(1'b0, 5);

        model_phase(1'b1, 300);
        drive(1'b1, 260);
        chk("hi300_stuck", 32'(stuck), 1);
        chk("hi300_stuck_lvl", 32'(stuck_level), 1);
        drive(1'b1, 40);
        ph(1'b0, 5);
        ph(1'b1, 5);
        ph(1'b0, 5);
        ph(1'b1, 5);
        ph(1'b0, 5);

        // High phase of exactly LIM cycles is the first one that times out.
        model_phase(1'b1, LIM);
        drive(1'b1, 10);
        chk("hilim_pre_stuck", 32'(stuck), 0);
        drive(1'b1, LIM - 10);
        model_phase(1'b0, 20);
        drive(1'b0, 4);
        chk("hilim_stuck", 32'(stuck), 1);
        chk("hilim_stuck_lvl", 32'(stuck_level), 1);
        drive(1'b0, 16);

        for (int i = 0; i < 40; i++) begin
            h = int'($urandom_range(1, 12));
            l = int'($urandom_range(1, 12));
            ph(1'b1, h);
            ph(1'b0, l);
        end

        // Enable dropped in the middle of a low phase.
        ph(1'b1, 5);
        ph(1'b0, 5);
        ph(1'b1, 5);
        model_phase(1'b0, 12);
        drive(1'b0, 5);
        en = 1'b0;
        restart_model();
        drive(1'b0, 1);
        chk("en_hold_high", 32'(high_cnt), 5);
        chk("en_hold_low", 32'(low_cnt), 5);
        chk("en_hold_period", 32'(period_cnt), 10);
        drive(1'b0, 3);
        en = 1'b1;
        drive(1'b0, 3);
        for (int i = 0; i < 3; i++) begin
            ph(1'b1, 5);
            ph(1'b0, 5);
        end

        // Asynchronous reset in the middle of a high phase.
        model_phase(1'b1, 6);
        drive(1'b1, 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_high", 32'(high_cnt), 0);
        chk("arst_low", 32'(low_cnt), 0);
        chk("arst_period", 32'(period_cnt), 0);
        chk("arst_valid", 32'(meas_valid), 0);
        chk("arst_stuck", 32'(stuck), 0);
        chk("arst_stuck_lvl", 32'(stuck_level), 0);
        @(posedge clk);
        #1;
        restart_model();
        model_phase(1'b0, 8);
        drive(1'b0, 2);
        rst_n = 1'b1;
        drive(1'b0, 6);
        for (int i = 0; i < 3; i++) begin
            ph(1'b1, 5);
            ph(1'b0, 5);
        end
        ph(1'b1, 5);
        drive(1'b0, 10);
        chk("drain_queue", 32'(q_h.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_duty_monitor.md
Name: clk_duty_monitor

Overview:
- Measures the frequency and duty cycle of an externally generated test clock (`mon_clk`), such as the output of the bench's programmable-frequency/duty clock source.
- Sits directly downstream of that source and samples it with the system clock `clk`.
- Reports high time, low time and period of each complete `mon_clk` cycle as counts of `clk` cycles, and flags a stuck (non-toggling) input.

Parameters:
- CNT_W, 16: width of the high and low counters; `period_cnt` is CNT_W+1 bits.
- SYNC_STAGES, 2: number of flops in the `mon_clk` synchronizer. Legal range is 2..4.

Ports:
- clk  input  1  system sampling clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  measurement enable, synchronous to `clk`.
- mon_clk  input  1  monitored clock, asynchronous to `clk`.
- high_cnt  output  CNT_W  `clk` cycles `mon_clk` was high in the last complete period.
- low_cnt  output  CNT_W  `clk` cycles `mon_clk` was low in the last complete period.
- period_cnt  output  CNT_W+1  high_cnt + low_cnt, zero-extended, no overflow.
- meas_valid  output  1  one-cycle pulse when high_cnt/low_cnt/period_cnt update.
- stuck  output  1  no edge seen for 2^CNT_W-1 `clk` cycles; sticky until the next valid measurement.
- stuck_level  output  1  synchronized `mon_clk` level when `stuck` was set.

Behaviour:
- Reset (rst_n=0, async): all outputs 0, synchronizer and edge register 0, FSM = IDLE.
- Synchronizer: SYNC_STAGES flops, then one edge-history flop.
  - rise = sync & ~prev; fall = ~sync & prev. Both are combinational, used in the same cycle.
- FSM states:
  - IDLE: counters cleared. Go to ALIGN when en=1.
  - ALIGN: discard partial period. On rise: hi_ctr<=1, go to MEAS_HI. Otherwise tmo_ctr increments.
  - MEAS_HI: on fall, hi_lat<=hi_ctr, lo_ctr<=1, go to MEAS_LO. Otherwise hi_ctr increments.
  - MEAS_LO: on rise, publish and pulse, hi_ctr<=1, stay back-to-back in MEAS_HI. Otherwise lo_ctr increments.
    - Publish means high_cnt<=hi_lat, low_cnt<=lo_ctr, period_cnt<=hi_lat+lo_ctr.
    - The pulse is meas_valid=1 for the following cycle only, and stuck<=0.
- Count semantics: the edge cycle counts as 1. A `mon_clk` synchronous to `clk` with H high and L low `clk` cycles yields high_cnt=H, low_cnt=L, period_cnt=H+L.
- Latency:
  - The first measurement follows one full `mon_clk` period after the first rise seen in ALIGN.
  - Outputs update 1 `clk` after the rise is detected.
  - Detection occurs SYNC_STAGES+1 `clk` edges after the `mon_clk` transition.
- Timeout/stuck:
  - If hi_ctr, lo_ctr or tmo_ctr reaches 2^CNT_W-1: stuck<=1, stuck_level<=sync, FSM -> ALIGN, counters cleared.
  - Counters never wrap.
  - `stuck` stays 1 through further timeouts and is cleared only on a meas_valid publish.
- en=0 in any state: next state IDLE, all counters cleared, meas_valid=0.
  - high_cnt, low_cnt, period_cnt, stuck and stuck_level hold their last values.
  - Re-enabling restarts from ALIGN, so no stale partial period is reported.
- Simultaneous events:
  - Timeout and an edge in the same cycle: the edge wins.
  - en=0 and rise in the same cycle: en wins, no publish.
- rise and fall cannot both occur in one cycle.
- A glitch of 1 synchronized cycle is counted as a legitimate phase of count 1.
- Reset mid-measurement: immediate clear; no meas_valid until a full new period completes.

Test Plan:
- clk=100 MHz, mon_clk=10 MHz, 50% duty, en=1 -> after the first full period, meas_valid pulses every 10 clk with high_cnt=5, low_cnt=5, period_cnt=10.
- mon_clk=10 MHz at 30% duty -> high_cnt=3, low_cnt=7, period_cnt=10; then switch to 70% -> the first following publish after one full period reports 7/3.
- CNT_W=8, mon_clk held 0 after en -> stuck=1, stuck_level=0 exactly 255 clk after entering ALIGN, meas_valid stays 0. Resume 5/5 toggling -> stuck clears on the first publish with 5/5/10.
- CNT_W=8, high phase of 300 clk -> timeout sets stuck=1, stuck_level=1, and no meas_valid for that period.
- Deassert en in MEAS_LO mid-period -> no pulse, outputs hold the prior 5/5/10. Re-assert -> the first pulse comes only after ALIGN plus one full period.
- Assert rst_n=0 mid MEAS_HI for 3 clk -> all outputs 0 asynchronously. After release, the first publish reports correct 5/5/10 with no partial period.
